// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter that shares the single register-file
//               write port between NREQ requesters via valid/ready. The
//               winning write is registered, giving one write per cycle at
//               a latency of one cycle. The quiesce input blocks new grants
//               so that in-flight writes can drain.
//               Optional macro RF_WRITE_BYPASS_EN forwards the write being
//               committed this cycle onto the read ports when addresses match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 2,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               quiesce,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic               idle,
    input  logic [AW-1:0]      rd_addr_a,
    input  logic [AW-1:0]      rd_addr_b,
    input  logic [DW-1:0]      rf_rdata_a,
    input  logic [DW-1:0]      rf_rdata_b,
    output logic [DW-1:0]      rd_data_a,
    output logic [DW-1:0]      rd_data_b
);

    // Pointer / select width; at least one bit so NREQ=1 stays legal.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_next;
    logic [PW-1:0]   w_sel;
    logic            w_any;
    logic [NREQ-1:0] w_grant;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;

    // Round-robin search: walk offsets from the farthest back to the nearest
    // so the requester closest to the pointer is the one left selected.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        if (!quiesce) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                for (int i = 0; i < NREQ; i++) begin
                    if ((((int'(r_ptr) + k) % NREQ) == i) && req_valid[i]) begin
                        w_sel = PW'(i);
                        w_any = 1'b1;
                    end
                end
            end
        end
    end

    // One-hot grant for the selected requester; suppressed while reset is held.
    always_comb begin
        w_grant = '0;
        if (w_any) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    assign req_ready  = w_grant & {NREQ{rst_n}};
    assign w_sel_addr = req_addr[w_sel*AW +: AW];
    assign w_sel_data = req_data[w_sel*DW +: DW];

    // Next pointer is the requester after the winner, wrapping modulo NREQ.
    generate
        if (NREQ == 1) begin : g_single_req
            assign w_ptr_next = '0;
        end else begin : g_multi_req
            assign w_ptr_next = (w_sel == PW'(NREQ - 1)) ? '0 : (w_sel + PW'(1));
        end
    endgenerate

    // Priority pointer advances only on an accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Output stage: register the accepted write; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_any;
            if (w_any) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign idle     = quiesce & ~r_we;

`ifdef RF_WRITE_BYPASS_EN
    // Forward the write committing this cycle so a same-register read sees it.
    assign rd_data_a = (r_we && (rd_addr_a == r_waddr)) ? r_wdata : rf_rdata_a;
    assign rd_data_b = (r_we && (rd_addr_b == r_waddr)) ? r_wdata : rf_rdata_b;
`else
    // Read addresses go straight to the register file; no local use here.
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^{rd_addr_a, rd_addr_b};
    assign rd_data_a        = rf_rdata_a;
    assign rd_data_b        = rf_rdata_b;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter
//               (NREQ=2, AW=2, DW=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int DW   = 8;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               quiesce;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic               idle;
    logic [AW-1:0]      rd_addr_a;
    logic [AW-1:0]      rd_addr_b;
    logic [DW-1:0]      rf_rdata_a;
    logic [DW-1:0]      rf_rdata_b;
    logic [DW-1:0]      rd_data_a;
    logic [DW-1:0]      rd_data_b;

    int errors = 0;
    int checks = 0;

    logic [NREQ-1:0] c_grants2 [4];
    logic [AW-1:0]   c_addrs2  [4];
    logic [DW-1:0]   c_bypass_exp;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .quiesce    (quiesce),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .idle       (idle),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        c_grants2[0] = 2'b01; c_grants2[1] = 2'b10; c_grants2[2] = 2'b01; c_grants2[3] = 2'b10;
        c_addrs2[0]  = 2'd1;  c_addrs2[1]  = 2'd3;  c_addrs2[2]  = 2'd1;  c_addrs2[3]  = 2'd3;
`ifdef RF_WRITE_BYPASS_EN
        c_bypass_exp = 8'h5A;
`else
        c_bypass_exp = 8'h00;
`endif

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_addr   = '0;
        req_data   = '0;
        quiesce    = 1'b0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        rf_rdata_a = '0;
        rf_rdata_b = '0;

        // Reset state; ready gated off even with valids high
        tick();
        chk("rst_we",    32'(rf_we),     32'd0);
        chk("rst_waddr", 32'(rf_waddr),  32'd0);
        chk("rst_wdata", 32'(rf_wdata),  32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Test 1: single write from requester 0
        rst_n     = 1'b1;
        req_valid = 2'b01;
        req_addr  = {2'd0, 2'd2};
        req_data  = {8'h00, 8'hA5};
        #1;
        chk("t1_ready", 32'(req_ready), 32'b01);
        tick();
        chk("t1_we",    32'(rf_we),    32'd1);
        chk("t1_waddr", 32'(rf_waddr), 32'd2);
        chk("t1_wdata", 32'(rf_wdata), 32'hA5);
        // Mid-write asynchronous reset
        rst_n = 1'b0;
        #1;
        chk("t1_arst_we",    32'(rf_we),     32'd0);
        chk("t1_arst_ready", 32'(req_ready), 32'd0);
        chk("t1_arst_waddr", 32'(rf_waddr),  32'd0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;

        // Test 2: both valid for four cycles, pointer back at 0 after reset
        req_valid = 2'b11;
        req_addr  = {2'd3, 2'd1};
        req_data  = {8'h33, 8'h11};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t2_ready%0d", c), 32'(req_ready), 32'(c_grants2[c]));
            tick();
            chk($sformatf("t2_we%0d", c),    32'(rf_we),    32'd1);
            chk($sformatf("t2_waddr%0d", c), 32'(rf_waddr), 32'(c_addrs2[c]));
        end
        req_valid = 2'b00;
        tick();
        chk("t2_idle_we",    32'(rf_we),    32'd0);
        chk("t2_hold_waddr", 32'(rf_waddr), 32'd3);
        chk("t2_hold_wdata", 32'(rf_wdata), 32'h33);

        // Test 3: requester 1 alone for three cycles, then both
        req_valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t3_ready%0d", c), 32'(req_ready), 32'b10);
            tick();
        end
        req_valid = 2'b11;
        #1;
        chk("t3_both_a", 32'(req_ready), 32'b01);
        tick();
        chk("t3_waddr_a", 32'(rf_waddr), 32'd1);
        #1;
        chk("t3_both_b", 32'(req_ready), 32'b10);
        tick();
        chk("t3_waddr_b", 32'(rf_waddr), 32'd3);
        req_valid = 2'b00;
        tick();

        // Test 4: quiesce blocks grants; a write granted just before drains
        quiesce   = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("t4_q_ready", 32'(req_ready), 32'd0);
        chk("t4_q_idle0", 32'(idle),      32'd1);
        tick();
        chk("t4_q_we",    32'(rf_we), 32'd0);
        chk("t4_q_idle1", 32'(idle),  32'd1);
        quiesce = 1'b0;
        #1;
        chk("t4_ready", 32'(req_ready), 32'b01);
        tick();
        quiesce = 1'b1;
        #1;
        chk("t4_drain_we",    32'(rf_we),     32'd1);
        chk("t4_drain_waddr", 32'(rf_waddr),  32'd1);
        chk("t4_drain_idle",  32'(idle),      32'd0);
        chk("t4_drain_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t4_after_we",   32'(rf_we), 32'd0);
        chk("t4_after_idle", 32'(idle),  32'd1);
        // Requester 1 takes its turn so the pointer returns to 0
        quiesce   = 1'b0;
        req_valid = 2'b10;
        #1;
        chk("t4_ptr_ready", 32'(req_ready), 32'b10);
        tick();

        // Test 5: valid dropped under quiesce never produces a write
        quiesce   = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("t5_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 2'b00;
        tick();
        chk("t5_we0", 32'(rf_we), 32'd0);
        tick();
        chk("t5_we1", 32'(rf_we), 32'd0);
        quiesce   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t5_ptr_ready", 32'(req_ready), 32'b01);
        tick();
        chk("t5_waddr", 32'(rf_waddr), 32'd1);

        // Test 6: read in the commit cycle of a write to the same register
        req_valid = 2'b01;
        req_addr  = {2'd3, 2'd2};
        req_data  = {8'h33, 8'h5A};
        #1;
        chk("t6_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid  = 2'b00;
        rd_addr_a  = 2'd2;
        rf_rdata_a = 8'h00;
        rd_addr_b  = 2'd1;
        rf_rdata_b = 8'hC3;
        #1;
        chk("t6_we",     32'(rf_we),     32'd1);
        chk("t6_waddr",  32'(rf_waddr),  32'd2);
        chk("t6_rdata_a", 32'(rd_data_a), 32'(c_bypass_exp));
        chk("t6_rdata_b", 32'(rd_data_b), 32'hC3);
        tick();
        rf_rdata_a = 8'h77;
        #1;
        chk("t6_nowrite_a", 32'(rd_data_a), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
